capture_ctrl: RTL and testbench

- Capture controller directly downstream of the sample/trigger/align pipeline, upstream of the memory writer.
- Consumes the aligned sample stream and forwards it to memory while armed.
- After the trigger (run) it counts a programmed number of post-trigger samples, then marks the final beat with tlast and stops.
- One registered output stage; full ready/valid backpressure on both sides.

---
 rtl/capture_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_capture_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// capture_ctrl: arms, triggers and closes a capture, forwarding the sample
// stream to memory with a single registered stage; optional CAPTURE_CTRL_TKEEP_EN.
module capture_ctrl #(
  parameter int SDW = 32,
  parameter int MDW = 32,
  parameter int MKW = MDW / 8,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  input  logic [31:0]    cfg_data,
  input  logic           arm,
  input  logic           run,
  input  logic           finish_now,
  input  logic [3:0]     disabled_groups,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic           sto_tlast,
  output logic [MKW-1:0] sto_tkeep,
  output logic [MDW-1:0] sto_tdata,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    S_IDLE, S_ARMED, S_TRIG, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  plen_q, plen_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           abort_q, abort_d;
  logic           vld_q, vld_d;
  logic           last_q, last_d;
  logic [MDW-1:0] data_q, data_d;
  logic [MKW-1:0] keep_q, keep_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           active;
  logic           accept;
  logic           last_beat;
  logic [MDW-1:0] beat_data;
  logic [MKW-1:0] beat_keep;

  assign active     = (state_q == S_ARMED) || (state_q == S_TRIG);
  assign sti_tready = active ? (!vld_q || sto_tready) : 1'b1;
  assign accept     = active && sti_tvalid && sti_tready;

`ifdef CAPTURE_CTRL_TKEEP_EN
  // Keep mask from the group enables; disabled bytes are zeroed
  always_comb begin
    beat_keep = '1;
    beat_data = sti_tdata;
    for (int i = 0; i < MKW; i++) begin
      if (i < 4) beat_keep[i] = !disabled_groups[i[1:0]];
      if (!beat_keep[i]) beat_data[8*i +: 8] = 8'h00;
    end
  end

  logic unused_cfg;
  assign unused_cfg = &{1'b0, cfg_data[31:CW]};
`else
  // All bytes valid, data passes through untouched
  always_comb begin
    beat_keep = '1;
    beat_data = sti_tdata;
  end

  logic unused_cfg;
  assign unused_cfg = &{1'b0, cfg_data[31:CW], disabled_groups};
`endif

  // Capture sequencing: arm, trigger, post-trigger count, abort
  always_comb begin
    state_d   = state_q;
    plen_d    = plen_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    last_beat = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_valid) plen_d = cfg_data[CW-1:0];
        if (arm) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (accept) begin
          if (abort_q || finish_now || (run && plen_q == '0)) begin
            last_beat = 1'b1;
            state_d   = S_DONE;
            abort_d   = 1'b0;
          end else if (run) begin
            state_d = S_TRIG;
            cnt_d   = plen_q - 1'b1;
          end
        end else begin
          if (finish_now) abort_d = 1'b1;
          if (run) begin
            state_d = S_TRIG;
            cnt_d   = plen_q;
          end
        end
      end
      S_TRIG: begin
        if (accept) begin
          if (abort_q || finish_now || cnt_q == '0) begin
            last_beat = 1'b1;
            state_d   = S_DONE;
            abort_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end else if (finish_now) begin
          abort_d = 1'b1;
        end
      end
      S_DONE: begin
        if (cfg_valid) plen_d = cfg_data[CW-1:0];
        if (arm && !vld_q) state_d = S_ARMED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output register: load on accept, empty once the sink takes it
  always_comb begin
    vld_d  = vld_q;
    last_d = last_q;
    data_d = data_q;
    keep_d = keep_q;
    if (accept) begin
      vld_d  = 1'b1;
      last_d = last_beat;
      data_d = beat_data;
      keep_d = beat_keep;
    end else if (sto_tready) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end
    busy_d = (state_d == S_ARMED) || (state_d == S_TRIG);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      plen_q  <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      keep_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      plen_q  <= plen_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sto_tvalid = vld_q;
  assign sto_tlast  = last_q;
  assign sto_tdata  = data_q;
  assign sto_tkeep  = keep_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: vector table, directed corner sequences and random
// traffic against a capture-level reference model.
module tb_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic [31:0] cfg_data;
  logic        arm, run, finish_now;
  logic [3:0]  disabled_groups;
  logic        sti_tready, sti_tvalid;
  logic [31:0] sti_tdata;
  logic        sto_tready, sto_tvalid, sto_tlast;
  logic [3:0]  sto_tkeep;
  logic [31:0] sto_tdata;
  logic        busy, done;

  capture_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .arm(arm), .run(run), .finish_now(finish_now),
    .disabled_groups(disabled_groups),
    .sti_tready(sti_tready), .sti_tvalid(sti_tvalid),
    .sti_tdata(sti_tdata),
    .sto_tready(sto_tready), .sto_tvalid(sto_tvalid),
    .sto_tlast(sto_tlast), .sto_tkeep(sto_tkeep),
    .sto_tdata(sto_tdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: capture phase flags and remaining post-trigger beats
  bit          m_armed, m_trig, m_done, m_abort, m_acc;
  int          m_plen, m_rem;
  bit          m_vld, m_last;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic [32:0] got[$];

  typedef struct {
    logic arm, run, fin, cfgv;
    logic [31:0] cfgd;
    logic tv;
    logic [31:0] td;
    logic tr;
    logic e_vld, e_last;
    logic [31:0] e_data;
    logic e_busy, e_done, e_rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] keepv();
`ifdef CAPTURE_CTRL_TKEEP_EN
    return ~disabled_groups;
`else
    return 4'hf;
`endif
  endfunction

  function automatic logic [31:0] maskd(input logic [31:0] d);
    logic [3:0] k;
    logic [31:0] r;
    k = keepv();
    r = d;
    for (int i = 0; i < 4; i++) if (!k[i]) r[8*i +: 8] = 8'h00;
    return r;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_trig = 0; m_done = 0; m_abort = 0; m_acc = 0;
    m_plen = 0; m_rem = 0;
    m_vld = 0; m_last = 0; m_data = 0; m_keep = 4'hf;
  endtask

  task automatic model_update();
    bit act, L, was_vld;
    act = m_armed;
    was_vld = m_vld;
    m_acc = act && sti_tvalid && (!m_vld || sto_tready);
    if (m_acc) begin
      L = 0;
      if (!m_trig && run) begin m_trig = 1; m_rem = m_plen + 1; end
      if (m_trig) begin m_rem--; if (m_rem == 0) L = 1; end
      if (m_abort || finish_now) L = 1;
      m_vld = 1; m_last = L;
      m_data = maskd(sti_tdata); m_keep = keepv();
      if (L) begin m_armed = 0; m_trig = 0; m_done = 1; m_abort = 0; end
    end else begin
      if (sto_tready) begin m_vld = 0; m_last = 0; end
      if (act) begin
        if (finish_now) m_abort = 1;
        if (!m_trig && run) begin m_trig = 1; m_rem = m_plen + 1; end
      end
    end
    if (!act) begin
      if (cfg_valid) m_plen = int'(cfg_data[15:0]);
      if (arm && (!m_done || !was_vld)) begin m_armed = 1; m_done = 0; end
    end
  endtask

  task automatic check_model();
    logic exp_rdy;
    exp_rdy = m_armed ? (!m_vld || sto_tready) : 1'b1;
    chk("sti_tready", sti_tready, exp_rdy);
    chk("sto_tvalid", sto_tvalid, m_vld);
    chk("sto_tlast", sto_tlast, m_last);
    chk("sto_tdata", sto_tdata, m_data);
    chk("sto_tkeep", sto_tkeep, m_keep);
    chk("busy", busy, m_armed);
    chk("done", done, m_done);
    if (sto_tvalid && sto_tready) got.push_back({sto_tlast, sto_tdata});
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cfg_valid = 0; cfg_data = 0; arm = 0; run = 0; finish_now = 0;
    sti_tvalid = 0; sti_tdata = 0; sto_tready = 1;
  endtask

  task automatic beat(input logic [31:0] d, input bit r, input bit f);
    sti_tvalid = 1; sti_tdata = d; run = r; finish_now = f;
    step();
    sti_tvalid = 0; run = 0; finish_now = 0;
  endtask

  task automatic cfg(input logic [31:0] d);
    cfg_valid = 1; cfg_data = d;
    step();
    cfg_valid = 0;
  endtask

  task automatic do_arm();
    arm = 1;
    step();
    arm = 0;
  endtask

  task automatic drain(input int n);
    idle_in();
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic vec_t mk(
    input logic a, r, f, cv, input logic [31:0] cd,
    input logic tv, input logic [31:0] td, input logic tr,
    input logic ev, el, input logic [31:0] ed,
    input logic eb, edn, er);
    vec_t v;
    v.arm = a; v.run = r; v.fin = f; v.cfgv = cv; v.cfgd = cd;
    v.tv = tv; v.td = td; v.tr = tr;
    v.e_vld = ev; v.e_last = el; v.e_data = ed;
    v.e_busy = eb; v.e_done = edn; v.e_rdy = er;
    return v;
  endfunction

  initial begin
    int cyc;
    logic [31:0] d;
    rst = 1;
    disabled_groups = 4'h0;
    idle_in();
    model_reset();
    #12;
    chk("rst_tvalid", sto_tvalid, 1'b0);
    chk("rst_tlast", sto_tlast, 1'b0);
    chk("rst_tdata", sto_tdata, 32'h0);
    chk("rst_tkeep", sto_tkeep, 4'hf);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_tready", sti_tready, 1'b1);
    #1 rst = 0;
    @(posedge clk);
    #1;

    // basic capture: outputs expected within the cycle the row is driven
    tbl.push_back(mk(0,0,0,1,32'd3, 0,32'h0, 1, 0,0,32'h0, 0,0,1));
    tbl.push_back(mk(1,0,0,0,32'd0, 0,32'h0, 1, 0,0,32'h0, 0,0,1));
    tbl.push_back(mk(0,0,0,0,32'd0, 1,32'h10,1, 0,0,32'h0, 1,0,1));
    tbl.push_back(mk(0,0,0,0,32'd0, 1,32'h11,1, 1,0,32'h10,1,0,1));
    tbl.push_back(mk(0,0,0,0,32'd0, 1,32'h12,1, 1,0,32'h11,1,0,1));
    tbl.push_back(mk(0,0,0,0,32'd0, 1,32'h13,1, 1,0,32'h12,1,0,1));
    tbl.push_back(mk(0,0,0,0,32'd0, 1,32'h14,1, 1,0,32'h13,1,0,1));
    tbl.push_back(mk(0,1,0,0,32'd0, 1,32'h15,1, 1,0,32'h14,1,0,1));
    tbl.push_back(mk(0,0,0,0,32'd0, 1,32'h16,1, 1,0,32'h15,1,0,1));
    tbl.push_back(mk(0,0,0,0,32'd0, 1,32'h17,1, 1,0,32'h16,1,0,1));
    tbl.push_back(mk(0,0,0,0,32'd0, 1,32'h18,1, 1,0,32'h17,1,0,1));
    tbl.push_back(mk(0,0,0,0,32'd0, 1,32'h19,1, 1,1,32'h18,0,1,1));
    tbl.push_back(mk(0,0,0,0,32'd0, 0,32'h0, 1, 0,0,32'h0, 0,1,1));
    foreach (tbl[i]) begin
      arm = tbl[i].arm; run = tbl[i].run; finish_now = tbl[i].fin;
      cfg_valid = tbl[i].cfgv; cfg_data = tbl[i].cfgd;
      sti_tvalid = tbl[i].tv; sti_tdata = tbl[i].td;
      sto_tready = tbl[i].tr;
      @(negedge clk);
      chk($sformatf("tbl%0d_tvalid", i), sto_tvalid, tbl[i].e_vld);
      if (tbl[i].e_vld) begin
        chk($sformatf("tbl%0d_tlast", i), sto_tlast, tbl[i].e_last);
        chk($sformatf("tbl%0d_tdata", i), sto_tdata, tbl[i].e_data);
      end
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("tbl%0d_tready", i), sti_tready, tbl[i].e_rdy);
      check_model();
      model_update();
      @(posedge clk);
      #1;
    end
    drain(2);

    // backpressure: sink ready one cycle in three
    got.delete();
    do_arm();
    d = 32'h10; cyc = 0;
    while (!m_done && cyc < 200) begin
      sto_tready = (cyc % 3 == 0);
      sti_tvalid = 1; sti_tdata = d; run = (d == 32'h15);
      step();
      if (m_acc) d++;
      cyc++;
    end
    chk("bp_timeout", cyc < 200, 1'b1);
    sto_tready = 0; sti_tvalid = 1; sti_tdata = 32'h19; run = 0;
    step();
    drain(3);
    chk("bp_count", got.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < got.size())
        chk($sformatf("bp_beat%0d", i), got[i], {i == 8, 32'h10 + i});

    // abort after seven post-trigger beats
    got.delete();
    cfg(32'h0000ffff);
    do_arm();
    beat(32'h100, 1, 0);
    for (int i = 1; i < 7; i++) beat(32'h100 + i, 0, 0);
    finish_now = 1; step(); finish_now = 0;
    beat(32'h107, 0, 0);
    beat(32'h108, 0, 0);
    beat(32'h109, 0, 0);
    drain(2);
    chk("abort_count", got.size(), 8);
    if (got.size() > 0) chk("abort_last", got[got.size()-1], {1'b1, 32'h107});
    if (got.size() > 6) chk("abort_mid", got[6], {1'b0, 32'h106});

    // post_len zero, run with the beat
    got.delete();
    cfg(32'h0);
    do_arm();
    beat(32'h300, 1, 0);
    beat(32'h301, 0, 0);
    drain(2);
    chk("plen0_count", got.size(), 1);
    if (got.size() > 0) chk("plen0_beat", got[0], {1'b1, 32'h300});

    // config write while triggered is ignored
    got.delete();
    cfg(32'd2);
    do_arm();
    beat(32'h400, 1, 0);
    cfg_valid = 1; cfg_data = 32'd9; step(); cfg_valid = 0;
    beat(32'h401, 0, 0);
    beat(32'h402, 0, 0);
    beat(32'h403, 0, 0);
    drain(2);
    chk("cfgtrig_count", got.size(), 3);
    if (got.size() > 2) chk("cfgtrig_last", got[2], {1'b1, 32'h402});

    // async reset with a stalled beat in the output register
    cfg(32'd5);
    do_arm();
    sto_tready = 0;
    beat(32'h500, 1, 0);
    step();
    chk("pre_rst_tvalid", sto_tvalid, 1'b1);
    #2 rst = 1;
    #1;
    chk("async_tvalid", sto_tvalid, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_tready", sti_tready, 1'b1);
    model_reset();
    idle_in();
    #1 rst = 0;
    @(posedge clk);
    #1;

    // arm and run together from IDLE: armed, not triggered
    got.delete();
    arm = 1; run = 1; step(); arm = 0; run = 0;
    disabled_groups = 4'b0101;
    beat(32'haabbccdd, 0, 0);
`ifdef CAPTURE_CTRL_TKEEP_EN
    chk("tkeep_en_keep", sto_tkeep, 4'b1010);
    chk("tkeep_en_data", sto_tdata, 32'haa00cc00);
`else
    chk("tkeep_keep", sto_tkeep, 4'b1111);
    chk("tkeep_data", sto_tdata, 32'haabbccdd);
`endif
    disabled_groups = 4'h0;
    beat(32'h601, 0, 0);
    beat(32'h602, 0, 0);
    chk("armrun_busy", busy, 1'b1);
    chk("armrun_done", done, 1'b0);
    beat(32'h600, 1, 0);
    drain(2);
    chk("postrst_count", got.size(), 4);
    if (got.size() > 3) chk("postrst_last", got[3], {1'b1, 32'h600});
    if (got.size() > 1) chk("postrst_mid", got[1], {1'b0, 32'h601});

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      arm        = ($urandom_range(0, 7) == 0);
      run        = ($urandom_range(0, 9) == 0);
      finish_now = ($urandom_range(0, 39) == 0);
      cfg_valid  = ($urandom_range(0, 19) == 0);
      cfg_data   = {$urandom_range(0, 65535), 16'(($urandom_range(0, 15) == 0)
                    ? $urandom_range(0, 65535) : $urandom_range(0, 20))};
      sti_tvalid = ($urandom_range(0, 3) != 0);
      sti_tdata  = $urandom;
      sto_tready = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 31) == 0) disabled_groups = 4'($urandom);
      step();
    end
    drain(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
